mdu: RTL and testbench

- Multiply/divide unit in the E stage, directly downstream of the decoder.
- Consumes the decoder's mult/multu/div/divu/mthi/mtlo/mfhi/mflo classification, encoded as MDU_op, together with the forwarded rs/rt operands.
- Owns the HI/LO architectural registers and models multi-cycle latency with a busy counter.
- The hazard unit stalls any MDU-class instruction in D while start or busy is high.

---
 rtl/mdu_pkg.sv | 35 +++
 rtl/mdu.sv | 197 +++++++++++++++++++
 tb/tb_mdu.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - MDU_op encodings (4 bits). The madd family codes are always reserved.
//     They are decoded only when MDU_MADD_EN is defined.
//   - rd_sel encodings for the HI/LO read mux.
//   - FSM state and accumulate-mode enums.
package mdu_pkg;

   localparam logic [3:0] MDU_NONE  = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MTHI  = 4'd5;
   localparam logic [3:0] MDU_MTLO  = 4'd6;
   localparam logic [3:0] MDU_MADD  = 4'd7;
   localparam logic [3:0] MDU_MADDU = 4'd8;
   localparam logic [3:0] MDU_MSUB  = 4'd9;
   localparam logic [3:0] MDU_MSUBU = 4'd10;

   localparam logic MDU_RD_LO = 1'b0;
   localparam logic MDU_RD_HI = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_t;

   // How the pending result is merged into HI/LO at completion.
   typedef enum logic [1:0] {
      ACC_NONE = 2'd0,
      ACC_ADD  = 2'd1,
      ACC_SUB  = 2'd2
   } acc_mode_t;

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit (E stage). Owns HI/LO; the result is computed
// combinationally at start and parked in pending registers. A down-counter
// then models the multi-cycle latency before HI/LO are written.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (and madd family), >= 1
//   DIV_CYCLES   busy cycles for div/divu, >= 1
// Ports:
//   clk      clock, rising edge
//   reset    asynchronous active-low reset
//   start    one-cycle issue pulse for mult/multu/div/divu
//   MDU_op   operation code (mdu_pkg encodings)
//   A, B     rs / rt operands
//   rd_sel   0 = LO, 1 = HI for MDU_out
//   busy     high while an operation is in flight
//   HI, LO   architectural HI/LO registers
//   MDU_out  rd_sel ? HI : LO (combinational)
// Build option:
//   MDU_MADD_EN  decodes madd/maddu/msub/msubu. These accumulate into the
//                HI/LO value present at completion.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no operation in flight; accepts start, mthi/mtlo
// ST_RUN  | counting down; HI/LO written on the edge where counter == 1
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  MDU_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        rd_sel,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDU_out
);

   localparam logic [15:0] CNT_MULT = 16'(MULT_CYCLES);
   localparam logic [15:0] CNT_DIV  = 16'(DIV_CYCLES);

   mdu_state_t state, state_nxt;
   logic [15:0] counter;
   logic [31:0] hi_q, lo_q, p_hi, p_lo;
   logic        p_dbz;
   acc_mode_t   p_acc;

   // products: operands are pre-extended so 64-bit truncation is exact
   logic [63:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
   assign a_sx   = {{32{A[31]}}, A};
   assign b_sx   = {{32{B[31]}}, B};
   assign a_zx   = {32'd0, A};
   assign b_zx   = {32'd0, B};
   assign prod_s = a_sx * b_sx;
   assign prod_u = a_zx * b_zx;

   // Dividing by zero, or -2^31 by -1, is replaced by a divide by 1. The
   // zero case is discarded later. The overflow case then yields the
   // wrapped quotient -2^31 with remainder 0, as required.
   logic               b_zero, div_ovf;
   logic signed [31:0] a_sg, b_sg, quo_s, rem_s;
   logic [31:0]        b_safe_u, quo_u, rem_u;
   assign b_zero   = (B == 32'd0);
   assign div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
   assign a_sg     = A;
   assign b_sg     = (b_zero || div_ovf) ? 32'sd1 : B;
   assign quo_s    = a_sg / b_sg;
   assign rem_s    = a_sg % b_sg;
   assign b_safe_u = b_zero ? 32'd1 : B;
   assign quo_u    = A / b_safe_u;
   assign rem_u    = A % b_safe_u;

   logic        op_launch, op_dbz;
   logic [15:0] op_cycles;
   logic [63:0] op_result;
   acc_mode_t   op_acc;

   always_comb begin
      op_launch = 1'b0;
      op_dbz    = 1'b0;
      op_cycles = CNT_MULT;
      op_result = prod_u;
      op_acc    = ACC_NONE;
      case (MDU_op)
         MDU_MULT: begin
            op_launch = 1'b1;
            op_result = prod_s;
         end
         MDU_MULTU: begin
            op_launch = 1'b1;
            op_result = prod_u;
         end
         MDU_DIV: begin
            op_launch = 1'b1;
            op_cycles = CNT_DIV;
            op_dbz    = b_zero;
            op_result = {rem_s, quo_s};
         end
         MDU_DIVU: begin
            op_launch = 1'b1;
            op_cycles = CNT_DIV;
            op_dbz    = b_zero;
            op_result = {rem_u, quo_u};
         end
`ifdef MDU_MADD_EN
         MDU_MADD: begin
            op_launch = 1'b1;
            op_result = prod_s;
            op_acc    = ACC_ADD;
         end
         MDU_MADDU: begin
            op_launch = 1'b1;
            op_result = prod_u;
            op_acc    = ACC_ADD;
         end
         MDU_MSUB: begin
            op_launch = 1'b1;
            op_result = prod_s;
            op_acc    = ACC_SUB;
         end
         MDU_MSUBU: begin
            op_launch = 1'b1;
            op_result = prod_u;
            op_acc    = ACC_SUB;
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start && op_launch) state_nxt = ST_RUN;
         ST_RUN:  if (counter == 16'd1)   state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         counter <= 16'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         p_hi    <= 32'd0;
         p_lo    <= 32'd0;
         p_dbz   <= 1'b0;
         p_acc   <= ACC_NONE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (op_launch) begin
                     {p_hi, p_lo} <= op_result;
                     p_dbz        <= op_dbz;
                     p_acc        <= op_acc;
                     counter      <= op_cycles;
                  end
               end else if (MDU_op == MDU_MTHI) begin
                  hi_q <= A;
               end else if (MDU_op == MDU_MTLO) begin
                  lo_q <= A;
               end
            end
            ST_RUN: begin
               counter <= counter - 16'd1;
               if (counter == 16'd1 && !p_dbz) begin
                  case (p_acc)
                     ACC_ADD: {hi_q, lo_q} <= {hi_q, lo_q} + {p_hi, p_lo};
                     ACC_SUB: {hi_q, lo_q} <= {hi_q, lo_q} - {p_hi, p_lo};
                     default: {hi_q, lo_q} <= {p_hi, p_lo};
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   assign busy    = (state == ST_RUN);
   assign HI      = hi_q;
   assign LO      = lo_q;
   assign MDU_out = (rd_sel == MDU_RD_HI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: the driver pushes expected HI/LO/latency for each
// multi-cycle op, the monitor pops on every falling edge of busy.
module tb_mdu;
   import mdu_pkg::*;

   localparam int MULT_CYCLES = 5;
   localparam int DIV_CYCLES  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  MDU_op = MDU_NONE;
   logic [31:0] A = 32'd0;
   logic [31:0] B = 32'd0;
   logic        rd_sel = 1'b0;
   logic        busy;
   logic [31:0] HI, LO, MDU_out;

   always #5 clk = ~clk;

   mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
      .clk(clk), .reset(reset), .start(start), .MDU_op(MDU_op),
      .A(A), .B(B), .rd_sel(rd_sel), .busy(busy),
      .HI(HI), .LO(LO), .MDU_out(MDU_out)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
      string       name;
   } exp_t;

   exp_t        sb_q[$];
   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic        mon_prev = 1'b0;
   int          mon_run = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Reference model: plain 64-bit arithmetic on the architectural HI/LO pair.
   // Returns the busy latency, or 0 when the op does not launch.
   function automatic int model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int ia, ib;
      longint sa, sb, q, r;
      longint unsigned ua, ub;
      logic [63:0] acc;
      ia = a; ib = b; sa = ia; sb = ib; ua = a; ub = b;
      acc = {m_hi, m_lo};
      case (op)
         MDU_MULT:  begin {m_hi, m_lo} = sa * sb; return MULT_CYCLES; end
         MDU_MULTU: begin {m_hi, m_lo} = ua * ub; return MULT_CYCLES; end
         MDU_DIV: begin
            if (b != 0) begin
               q = sa / sb; r = sa % sb;
               m_lo = q[31:0]; m_hi = r[31:0];
            end
            return DIV_CYCLES;
         end
         MDU_DIVU: begin
            if (b != 0) begin
               q = longint'(ua / ub); r = longint'(ua % ub);
               m_lo = q[31:0]; m_hi = r[31:0];
            end
            return DIV_CYCLES;
         end
`ifdef MDU_MADD_EN
         MDU_MADD:  begin {m_hi, m_lo} = acc + 64'(sa * sb); return MULT_CYCLES; end
         MDU_MADDU: begin {m_hi, m_lo} = acc + 64'(ua * ub); return MULT_CYCLES; end
         MDU_MSUB:  begin {m_hi, m_lo} = acc - 64'(sa * sb); return MULT_CYCLES; end
         MDU_MSUBU: begin {m_hi, m_lo} = acc - 64'(ua * ub); return MULT_CYCLES; end
`endif
         default: return 0;
      endcase
   endfunction

   task automatic wait_idle();
      int n = 0;
      while (busy === 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) begin
         total_cnt++;
         $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, n);
      end
   endtask

   task automatic issue(input logic st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int cyc;
      wait_idle();
      start = st; MDU_op = op; A = a; B = b;
      rd_sel = 1'($urandom_range(0, 1));
      cyc = 0;
      if (st) cyc = model_op(op, a, b);
      else if (op == MDU_MTHI) m_hi = a;
      else if (op == MDU_MTLO) m_lo = a;
      if (cyc > 0) sb_q.push_back('{m_hi, m_lo, cyc, $sformatf("op%0d_%h_%h", op, a, b)});
      @(negedge clk);
      start = 1'b0; MDU_op = MDU_NONE; A = $urandom; B = $urandom;
      if (cyc == 0) begin
         check32("nolaunch_busy", {31'd0, busy}, 32'd0);
         check32("direct_hi", HI, m_hi);
         check32("direct_lo", LO, m_lo);
         check32("direct_out", MDU_out, rd_sel ? m_hi : m_lo);
      end
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'($urandom_range(1, 20));
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // monitor: completion is the falling edge of busy while out of reset
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            mon_prev = 1'b0;
            mon_run  = 0;
         end else if (busy) begin
            mon_prev = 1'b1;
            mon_run++;
         end else if (mon_prev) begin
            mon_prev = 1'b0;
            if (sb_q.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_completion: busy fell after %0d cycles, no op pending", mon_run);
            end else begin
               e = sb_q.pop_front();
               check32({e.name, "_hi"}, HI, e.hi);
               check32({e.name, "_lo"}, LO, e.lo);
               check32({e.name, "_out"}, MDU_out, rd_sel ? e.hi : e.lo);
               check32({e.name, "_cycles"}, 32'(mon_run), 32'(e.cycles));
            end
            mon_run = 0;
         end
      end
   end

   initial begin
      logic [3:0] op;
      #1;
      check32("reset_busy", {31'd0, busy}, 32'd0);
      check32("reset_hi", HI, 32'd0);
      check32("reset_lo", LO, 32'd0);
      check32("reset_out", MDU_out, 32'd0);
      #11 reset = 1'b1;
      @(negedge clk);

      // plan 1/2: directed arithmetic with hard constants
      issue(1'b1, MDU_MULT, 32'hFFFF_FFFF, 32'h2);
      wait_idle();
      check32("t1_hi", HI, 32'hFFFF_FFFF);
      check32("t1_lo", LO, 32'hFFFF_FFFE);
      issue(1'b1, MDU_MULTU, 32'hFFFF_FFFF, 32'h2);
      wait_idle();
      check32("t2_multu_hi", HI, 32'h1);
      check32("t2_multu_lo", LO, 32'hFFFF_FFFE);
      issue(1'b1, MDU_DIV, 32'hFFFF_FFF9, 32'h2);
      wait_idle();
      check32("t2_div_hi", HI, 32'hFFFF_FFFF);
      check32("t2_div_lo", LO, 32'hFFFF_FFFD);
      issue(1'b1, MDU_DIVU, 32'd7, 32'd2);
      wait_idle();
      check32("t2_divu_hi", HI, 32'd1);
      check32("t2_divu_lo", LO, 32'd3);
      issue(1'b1, MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

      // plan 3: divide by zero leaves HI/LO alone
      issue(1'b0, MDU_MTHI, 32'h11, 32'd0);
      issue(1'b0, MDU_MTLO, 32'h22, 32'd0);
      issue(1'b1, MDU_DIV, 32'd5, 32'd0);
      wait_idle();
      check32("t3_hi", HI, 32'h11);
      check32("t3_lo", LO, 32'h22);

      // plan 4: reset during RUN aborts with no later writeback
      start = 1'b1; MDU_op = MDU_DIV; A = 32'd100; B = 32'd7;
      @(negedge clk);
      start = 1'b0; MDU_op = MDU_NONE;
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check32("t4_busy", {31'd0, busy}, 32'd0);
      check32("t4_hi", HI, 32'd0);
      check32("t4_lo", LO, 32'd0);
      m_hi = 32'd0; m_lo = 32'd0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      repeat (15) @(negedge clk);
      check32("t4_late_busy", {31'd0, busy}, 32'd0);
      check32("t4_late_hi", HI, 32'd0);
      check32("t4_late_lo", LO, 32'd0);

      // plan 5: mthi without busy; start mid-mult ignored
      issue(1'b0, MDU_MTHI, 32'h1234, 32'd0);
      check32("t5_mthi", HI, 32'h1234);
      issue(1'b1, MDU_MULT, 32'd7, 32'd9);
      @(negedge clk);
      start = 1'b1; MDU_op = MDU_MULT; A = 32'd3; B = 32'd3;
      @(negedge clk);
      start = 1'b0; MDU_op = MDU_NONE;
      wait_idle();
      check32("t5_lo", LO, 32'd63);
      issue(1'b1, MDU_NONE, 32'd1, 32'd1);
      issue(1'b1, MDU_MTLO, 32'hDEAD, 32'd1);

`ifdef MDU_MADD_EN
      // plan 6: accumulate into HI/LO
      issue(1'b0, MDU_MTHI, 32'd0, 32'd0);
      issue(1'b0, MDU_MTLO, 32'd5, 32'd0);
      issue(1'b1, MDU_MADD, 32'd3, 32'd4);
      wait_idle();
      check32("t6_madd_hi", HI, 32'd0);
      check32("t6_madd_lo", LO, 32'd17);
      issue(1'b1, MDU_MSUBU, 32'd1, 32'd18);
      wait_idle();
      check32("t6_msubu_hi", HI, 32'hFFFF_FFFF);
      check32("t6_msubu_lo", LO, 32'hFFFF_FFFF);
`endif

      // random traffic; madd codes act as none when the feature is off
      for (int i = 0; i < 80; i++) begin
         op = 4'($urandom_range(0, 10));
         if ((op == MDU_MTHI || op == MDU_MTLO) && $urandom_range(0, 1) == 0)
            issue(1'b0, op, rand_operand(), rand_operand());
         else
            issue(1'b1, op, rand_operand(), rand_operand());
      end

      wait_idle();
      repeat (3) @(negedge clk);
      check32("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
